// File: rtl/mips_mc_ctrl_if.sv
// mips_mc_ctrl_if: instruction, handshake and strobe bundle between the multi-cycle controller and datapath
interface mips_mc_ctrl_if #(parameter int CNT_W = 32);
  logic [31:0] instr;
  logic zero, im_ready, dm_ready;
  logic PCWr, IRWr, RegWr, MemWr, dm_req, ALUSrc, illegal;
  logic [2:0] ALUOp, state;
  logic [1:0] RegDst, Mem2Reg, ExtOp, NPCOp;
  logic [CNT_W-1:0] cycle_cnt, instr_cnt;
  modport master(
    input instr, zero, im_ready, dm_ready,
    output PCWr, IRWr, RegWr, MemWr, dm_req, ALUSrc, illegal, ALUOp, state,
           RegDst, Mem2Reg, ExtOp, NPCOp, cycle_cnt, instr_cnt
  );
  modport slave(
    output instr, zero, im_ready, dm_ready,
    input PCWr, IRWr, RegWr, MemWr, dm_req, ALUSrc, illegal, ALUOp, state,
          RegDst, Mem2Reg, ExtOp, NPCOp, cycle_cnt, instr_cnt
  );
endinterface

// File: rtl/mips_mc_ctrl.sv
// mips_mc_ctrl: multi-cycle MIPS control FSM (FETCH/DECODE/EXEC/MEM/WB) with saturating CPI counters
module mips_mc_ctrl #(parameter int CNT_W = 32) (
  input logic clk,
  input logic rst,
  mips_mc_ctrl_if.master bus
);
  typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB} state_t;
  state_t state_q, state_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d, instr_cnt_q, instr_cnt_d;
  logic [5:0] op, fn;
  logic r_t, addu, subu, jr, ori, lui, lw, sw, beq, j, jal, jump, legal, retire;
  always_comb begin
    op = bus.instr[31:26];
    fn = bus.instr[5:0];
    r_t = op == 6'b000000;
    addu = r_t && fn == 6'b100001;
    subu = r_t && fn == 6'b100011;
    jr = r_t && fn == 6'b001000;
    ori = op == 6'b001101;
    lui = op == 6'b001111;
    lw = op == 6'b100011;
    sw = op == 6'b101011;
    beq = op == 6'b000100;
    j = op == 6'b000010;
    jal = op == 6'b000011;
    jump = j || jal || jr;
    legal = addu || subu || jump || ori || lui || lw || sw || beq;
  end
  always_comb begin
    state_d = state_q;
    retire = 1'b0;
    bus.PCWr = 1'b0;
    bus.IRWr = 1'b0;
    bus.RegWr = 1'b0;
    bus.MemWr = 1'b0;
    bus.dm_req = 1'b0;
    bus.illegal = 1'b0;
    bus.ALUSrc = 1'b0;
    bus.ALUOp = 3'b000;
    bus.RegDst = 2'b00;
    bus.Mem2Reg = 2'b00;
    bus.ExtOp = 2'b00;
    bus.NPCOp = 2'b00;
    // IR holds the instruction, so EXEC selects stay valid through MEM and WB
    if (state_q == EXEC || state_q == MEM || state_q == WB) begin
      bus.ALUOp = (subu || beq) ? 3'b001 : ori ? 3'b010 : lui ? 3'b011 : 3'b000;
      bus.ALUSrc = ori || lui || lw || sw;
      bus.ExtOp = lui ? 2'b10 : (lw || sw) ? 2'b01 : 2'b00;
    end
    case (state_q)
      FETCH: begin
        bus.PCWr = bus.im_ready;
        bus.IRWr = bus.im_ready;
        state_d = bus.im_ready ? DECODE : FETCH;
      end
      DECODE: begin
        bus.PCWr = jump;
        bus.NPCOp = jr ? 2'b11 : (j || jal) ? 2'b10 : 2'b00;
        bus.RegWr = jal;
        bus.RegDst = jal ? 2'b10 : 2'b00;
        bus.Mem2Reg = jal ? 2'b10 : 2'b00;
        bus.illegal = !legal;
        retire = jump || !legal;
        state_d = retire ? FETCH : EXEC;
      end
      EXEC: begin
        bus.PCWr = beq && bus.zero;
        bus.NPCOp = beq ? 2'b01 : 2'b00;
        retire = beq;
        state_d = beq ? FETCH : (lw || sw) ? MEM : WB;
      end
      MEM: begin
        bus.dm_req = 1'b1;
        bus.MemWr = sw;
        retire = bus.dm_ready && sw;
        state_d = !bus.dm_ready ? MEM : sw ? FETCH : WB;
      end
      WB: begin
        bus.RegWr = 1'b1;
        bus.RegDst = r_t ? 2'b01 : 2'b00;
        bus.Mem2Reg = lw ? 2'b01 : 2'b00;
        retire = 1'b1;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    cycle_cnt_d = &cycle_cnt_q ? cycle_cnt_q : cycle_cnt_q + CNT_W'(1);
    instr_cnt_d = (retire && !(&instr_cnt_q)) ? instr_cnt_q + CNT_W'(1) : instr_cnt_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= FETCH;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q <= state_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  assign bus.state = state_q;
  assign bus.cycle_cnt = cycle_cnt_q;
  assign bus.instr_cnt = instr_cnt_q;
endmodule

// File: tb/tb_mips_mc_ctrl.sv
// tb_mips_mc_ctrl: directed checks of the multi-cycle controller, plus a 4-bit counter build for saturation
module tb_mips_mc_ctrl;
  logic clk = 1'b0;
  logic rst, rst_b;
  int checks = 0;
  int failures = 0;
  mips_mc_ctrl_if #(.CNT_W(32)) ifa();
  mips_mc_ctrl_if #(.CNT_W(4)) ifb();
  mips_mc_ctrl #(.CNT_W(32)) dut(.clk(clk), .rst(rst), .bus(ifa));
  mips_mc_ctrl #(.CNT_W(4)) dut_b(.clk(clk), .rst(rst_b), .bus(ifb));
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  // runs one instruction from FETCH back to FETCH, tallying strobes and selects along the way
  task automatic run(input string tag, input logic [31:0] ins, input logic z, input int imw, input int dmw,
                     input int e_cyc, input int e_pc, input int e_ir, input int e_rw, input int e_mw,
                     input int e_ill, input logic [5:0] e_ex, input logic [3:0] e_wb, input logic [1:0] e_np);
    int cyc = 0, pc = 0, ir = 0, rw = 0, mw = 0, il = 0, fc = 0, mc = 0;
    bit left = 0;
    logic [3:0] wb = '0;
    logic [1:0] np = '0;
    ifa.instr = ins;
    ifa.zero = z;
    do begin
      ifa.im_ready = fc >= imw;
      ifa.dm_ready = mc >= dmw;
      #1;
      pc += int'(ifa.PCWr);
      ir += int'(ifa.IRWr);
      rw += int'(ifa.RegWr);
      mw += int'(ifa.MemWr);
      il += int'(ifa.illegal);
      if (ifa.state >= 3'd2) chk({tag, " sel"}, {ifa.ALUOp, ifa.ALUSrc, ifa.ExtOp}, e_ex);
      if (ifa.RegWr) wb = {ifa.RegDst, ifa.Mem2Reg};
      if (ifa.PCWr && ifa.state != 3'd0) np = ifa.NPCOp;
      if (ifa.state == 3'd0) fc++;
      if (ifa.state == 3'd3) mc++;
      if (ifa.state != 3'd0) left = 1;
      cyc++;
      tick();
    end while (!(left && ifa.state == 3'd0) && cyc < 30);
    ifa.im_ready = 1'b0;
    ifa.dm_ready = 1'b0;
    chk({tag, " cycles"}, cyc, e_cyc);
    chk({tag, " PCWr"}, pc, e_pc);
    chk({tag, " IRWr"}, ir, e_ir);
    chk({tag, " RegWr"}, rw, e_rw);
    chk({tag, " MemWr"}, mw, e_mw);
    chk({tag, " illegal"}, il, e_ill);
    chk({tag, " wbsel"}, wb, e_wb);
    chk({tag, " npc"}, np, e_np);
  endtask
  initial begin
    rst = 1'b0;
    rst_b = 1'b0;
    ifa.instr = '0;
    ifa.zero = 1'b0;
    ifa.im_ready = 1'b0;
    ifa.dm_ready = 1'b0;
    ifb.instr = 32'h08000000;
    ifb.zero = 1'b0;
    ifb.im_ready = 1'b1;
    ifb.dm_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst state", ifa.state, 0);
    chk("rst strobes", {ifa.PCWr, ifa.IRWr, ifa.RegWr, ifa.MemWr, ifa.dm_req, ifa.illegal}, 0);
    chk("rst cycle", ifa.cycle_cnt, 0);
    chk("rst instr", ifa.instr_cnt, 0);
    rst = 1'b1;
    rst_b = 1'b1;
    tick();
    chk("cyc1", ifa.cycle_cnt, 1);
    chk("fetch idle", ifa.state, 0);
    tick();
    chk("cyc2", ifa.cycle_cnt, 2);
    run("addu", 32'h00000021, 0, 0, 0, 4, 1, 1, 1, 0, 0, 6'b000000, 4'b0100, 2'b00);
    run("ori", 32'h34000000, 0, 0, 0, 4, 1, 1, 1, 0, 0, 6'b010100, 4'b0000, 2'b00);
    run("lw", 32'h8C000000, 0, 0, 0, 5, 1, 1, 1, 0, 0, 6'b000101, 4'b0001, 2'b00);
    run("sw", 32'hAC000000, 0, 0, 0, 4, 1, 1, 0, 1, 0, 6'b000101, 4'b0000, 2'b00);
    run("beq_t", 32'h10000000, 1, 0, 0, 3, 2, 1, 0, 0, 0, 6'b001000, 4'b0000, 2'b01);
    run("j", 32'h08000000, 0, 0, 0, 2, 2, 1, 0, 0, 0, 6'b000000, 4'b0000, 2'b10);
    chk("seq cycle", ifa.cycle_cnt, 24);
    chk("seq instr", ifa.instr_cnt, 6);
    run("beq_nt", 32'h10000000, 0, 0, 0, 3, 1, 1, 0, 0, 0, 6'b001000, 4'b0000, 2'b00);
    run("lw_wait", 32'h8C000000, 0, 3, 2, 10, 1, 1, 1, 0, 0, 6'b000101, 4'b0001, 2'b00);
    run("subu", 32'h00000023, 0, 0, 0, 4, 1, 1, 1, 0, 0, 6'b001000, 4'b0100, 2'b00);
    run("lui", 32'h3C000000, 0, 0, 0, 4, 1, 1, 1, 0, 0, 6'b011110, 4'b0000, 2'b00);
    run("jal", 32'h0C000000, 0, 0, 0, 2, 2, 1, 1, 0, 0, 6'b000000, 4'b1010, 2'b10);
    run("jr", 32'h00000008, 0, 0, 0, 2, 2, 1, 0, 0, 0, 6'b000000, 4'b0000, 2'b11);
    chk("all cycle", ifa.cycle_cnt, 49);
    chk("all instr", ifa.instr_cnt, 12);
    ifa.instr = 32'hAC000000;
    ifa.dm_ready = 1'b0;
    ifa.im_ready = 1'b1;
    tick();
    ifa.im_ready = 1'b0;
    tick();
    tick();
    chk("mid state", ifa.state, 3);
    chk("mid MemWr", {ifa.MemWr, ifa.dm_req}, 2'b11);
    rst = 1'b0;
    #1;
    chk("mid rst drop", {ifa.MemWr, ifa.dm_req}, 0);
    chk("mid rst state", ifa.state, 0);
    tick();
    rst = 1'b1;
    tick();
    chk("post rst state", ifa.state, 0);
    chk("post rst instr", ifa.instr_cnt, 0);
    run("illegal", 32'hFC000000, 0, 0, 0, 2, 1, 1, 0, 0, 1, 6'b000000, 4'b0000, 2'b00);
    chk("illegal retire", ifa.instr_cnt, 1);
    chk("sat cycle", ifb.cycle_cnt, 15);
    chk("sat instr", ifb.instr_cnt, 15);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
